// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared constants, types and helpers for the RV32IM execute stage
package execute_pkg;

  // ALU operation codes carried in ALUControlE
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Forwarding mux selects; 2'b11 falls back to the register value
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic        regwrite;
    logic [1:0]  result_src;
    logic        memwrite;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } exmem_t;

  function automatic logic [31:0] fwd_sel(input logic [31:0] reg_val,
                                          input logic [1:0]  sel,
                                          input logic [31:0] wb_val,
                                          input logic [31:0] mem_val);
    case (sel)
      FWD_REG: return reg_val;
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/Divider.sv
// rtl/Divider.sv - iterative radix-2 restoring divider with sign fix-up
module Divider
  import execute_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             rem_sel_q, rem_sel_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             a_neg, b_neg;
  logic [XLEN:0]    shifted, diff;

  assign a_neg   = signed_i & a_i[XLEN-1];
  assign b_neg   = signed_i & b_i[XLEN-1];
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Next state: wait for a divide, run XLEN steps, hold the result for one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start_i) state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Datapath: capture magnitudes on start, then one restoring step per BUSY cycle
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (state_q == DIV_IDLE && start_i) begin
      cnt_d     = '0;
      quo_d     = a_neg ? -a_i : a_i;
      dvs_d     = b_neg ? -b_i : b_i;
      rem_d     = '0;
      rem_sel_d = rem_i;
      // Divide by zero must return all-ones regardless of operand signs
      neg_quo_d = (a_neg ^ b_neg) && (b_i != '0);
      neg_rem_d = a_neg;
    end else if (state_q == DIV_BUSY) begin
      cnt_d = cnt_q + 1'b1;
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // State and datapath registers; reset abandons any divide in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy_o   = (state_q == DIV_BUSY);
  assign done_o   = (state_q == DIV_DONE);
  assign result_o = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32IM execute stage: forwarding, ALU, multiplier, divider, EX/MEM register
module execute_stage
  import execute_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic [3:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic            MulDivE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            StallE,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PCPlus4M
);

  exmem_t            exmem_q, exmem_d;
  logic [XLEN-1:0]   src_a, src_b, write_data_e;
  logic [XLEN-1:0]   alu_result, mul_result, div_result;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [4:0]        shamt;
  logic              div_in_e, div_signed, div_rem, div_busy, div_done;

  assign src_a        = fwd_sel(RD1E, ForwardAE, ResultW, exmem_q.alu_result);
  assign write_data_e = fwd_sel(RD2E, ForwardBE, ResultW, exmem_q.alu_result);
  assign src_b        = ALUSrcE ? ImmExtE : write_data_e;
  assign shamt        = src_b[4:0];

  // Single-cycle integer ALU
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  // Full-width product: operands are sign- or zero-extended to 2*XLEN per variant
  always_comb begin
    mul_a      = (Funct3E == F3_MULHU) ? {{XLEN{1'b0}}, src_a} : {{XLEN{src_a[XLEN-1]}}, src_a};
    mul_b      = (Funct3E == F3_MULH)  ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
    product    = mul_a * mul_b;
    mul_result = (Funct3E == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  assign div_in_e   = MulDivE && (Funct3E inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});
  assign div_signed = !(Funct3E inside {F3_DIVU, F3_REMU});
  assign div_rem    = Funct3E inside {F3_REM, F3_REMU};

  Divider #(.XLEN(XLEN)) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (div_in_e),
    .signed_i (div_signed),
    .rem_i    (div_rem),
    .a_i      (src_a),
    .b_i      (src_b),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .result_o (div_result)
  );

  // Hold the front end from the start cycle through every BUSY step; release on DONE
  assign StallE = rst_n && div_in_e && (div_busy || !div_done);

  // EX/MEM next value: a bubble while stalled, otherwise the E-side bundle
  always_comb begin
    exmem_d = '0;
    if (!StallE) begin
      exmem_d.regwrite   = RegWriteE;
      exmem_d.result_src = ResultSrcE;
      exmem_d.memwrite   = MemWriteE;
      exmem_d.write_data = write_data_e;
      exmem_d.rd         = RdE;
      exmem_d.pc_plus4   = PCPlus4E;
      if (div_in_e)     exmem_d.alu_result = div_result;
      else if (MulDivE) exmem_d.alu_result = mul_result;
      else              exmem_d.alu_result = alu_result;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign RegWriteM  = exmem_q.regwrite;
  assign ResultSrcM = exmem_q.result_src;
  assign MemWriteM  = exmem_q.memwrite;
  assign ALUResultM = exmem_q.alu_result;
  assign WriteDataM = exmem_q.write_data;
  assign RdM        = exmem_q.rd;
  assign PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE, MemWriteE, ALUSrcE, MulDivE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        StallE, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MulDivE(MulDivE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallE(StallE), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_alu_m;
  logic        exp_is_div, exp_rw, exp_mw;
  logic [1:0]  exp_rs;
  logic [4:0]  exp_rd;
  logic [31:0] exp_res, exp_wd, exp_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [31:0] v, input logic [1:0] sel, input logic [31:0] rw);
    if (sel == 2'b01) return rw;
    if (sel == 2'b10) return exp_alu_m;
    return v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'd7: return 32'(64'(a) * (64'd1 << b[4:0]));
      4'd8: return 32'(64'(a) / (64'd1 << b[4:0]));
      4'd9: return 32'(sa >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[63:32]; end
      3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'd0, b})); return p[63:32]; end
      default: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 32'd0) return (f3[1]) ? a : 32'hFFFF_FFFF;
    case (f3)
      3'd4: return 32'(sa / sb);
      3'd5: return 32'(ua / ub);
      3'd6: return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  task automatic drive_op(input logic md, input logic [2:0] f3, input logic [3:0] aluc, input logic alusrc,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw);
    logic [31:0] a, wd, b;
    RegWriteE = 1'($urandom); ResultSrcE = 2'($urandom); MemWriteE = 1'($urandom);
    RdE = 5'($urandom); PCPlus4E = $urandom;
    MulDivE = md; Funct3E = f3; ALUControlE = aluc; ALUSrcE = alusrc;
    RD1E = rd1; RD2E = rd2; ImmExtE = imm; ForwardAE = fa; ForwardBE = fb; ResultW = rw;
    a  = fwd(rd1, fa, rw);
    wd = fwd(rd2, fb, rw);
    b  = alusrc ? imm : wd;
    exp_is_div = md && f3[2];
    if (!md)        exp_res = ref_alu(aluc, a, b);
    else if (f3[2]) exp_res = ref_div(f3, a, b);
    else            exp_res = ref_mul(f3, a, b);
    exp_wd = wd; exp_rw = RegWriteE; exp_rs = ResultSrcE; exp_mw = MemWriteE;
    exp_rd = RdE; exp_pc = PCPlus4E;
  endtask

  task automatic finish_op(input string tag);
    int n, bad;
    n = 0; bad = 0;
    #1;
    if (exp_is_div) begin
      while (StallE === 1'b1 && n < 60) begin
        n++;
        @(posedge clk); #1;
        if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ALUResultM !== 32'd0 || RdM !== 5'd0) bad++;
        ResultW = $urandom;
        #1;
      end
      check({tag, "_stall"}, 64'(n), 64'd33);
      check({tag, "_bubble"}, 64'(bad), 64'd0);
      exp_alu_m = 32'd0;
      exp_wd = fwd(RD2E, ForwardBE, ResultW);
    end else begin
      check({tag, "_nostall"}, 64'(StallE), 64'd0);
    end
    @(posedge clk); #1;
    exp_alu_m = exp_res;
    check({tag, "_res"}, 64'(ALUResultM), 64'(exp_res));
    check({tag, "_wdata"}, 64'(WriteDataM), 64'(exp_wd));
    check({tag, "_ctl"}, 64'({RegWriteM, ResultSrcM, MemWriteM, RdM}), 64'({exp_rw, exp_rs, exp_mw, exp_rd}));
    check({tag, "_pc"}, 64'(PCPlus4M), 64'(exp_pc));
  endtask

  task automatic do_op(input string tag, input logic md, input logic [2:0] f3, input logic [3:0] aluc,
                       input logic alusrc, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [1:0] fa);
    drive_op(md, f3, aluc, alusrc, rd1, rd2, imm, fa, 2'b00, $urandom);
    finish_op(tag);
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_alu"}, 64'(ALUResultM), 64'd0);
    check({tag, "_wdata"}, 64'(WriteDataM), 64'd0);
    check({tag, "_pc"}, 64'(PCPlus4M), 64'd0);
    check({tag, "_ctl"}, 64'({RegWriteM, ResultSrcM, MemWriteM, RdM}), 64'd0);
    check({tag, "_stall"}, 64'(StallE), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int kind;
    logic [31:0] r1, r2;
    exp_alu_m = 32'd0;
    rst_n = 1'b0;
    RegWriteE = 1'b0; ResultSrcE = 2'd0; MemWriteE = 1'b0; ALUControlE = 4'd0; ALUSrcE = 1'b0;
    MulDivE = 1'b1; Funct3E = 3'd4; RD1E = 32'd9; RD2E = 32'd3; ImmExtE = 32'd0; PCPlus4E = 32'd0;
    RdE = 5'd0; ForwardAE = 2'd0; ForwardBE = 2'd0; ResultW = 32'd0;
    #1;
    check_m_zero("reset");
    MulDivE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_op("add_imm", 1'b0, 3'd0, 4'd0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFD, 2'b00);
    check("add_imm_val", 64'(ALUResultM), 64'd2);
    do_op("add7", 1'b0, 3'd0, 4'd0, 1'b1, 32'd3, 32'd0, 32'd4, 2'b00);
    do_op("fwd_mem", 1'b0, 3'd0, 4'd0, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'd0, 2'b10);
    check("fwd_mem_val", 64'(ALUResultM), 64'd7);
    do_op("sra", 1'b0, 3'd0, 4'd9, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 2'b00);
    check("sra_val", 64'(ALUResultM), 64'hF800_0000);
    do_op("sltu", 1'b0, 3'd0, 4'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 2'b00);
    check("sltu_val", 64'(ALUResultM), 64'd1);
    do_op("slt", 1'b0, 3'd0, 4'd5, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 2'b00);
    check("slt_val", 64'(ALUResultM), 64'd0);
    do_op("mulh", 1'b1, 3'd1, 4'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b00);
    check("mulh_val", 64'(ALUResultM), 64'd0);
    do_op("mulhu", 1'b1, 3'd3, 4'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b00);
    check("mulhu_val", 64'(ALUResultM), 64'hFFFF_FFFE);
    do_op("mul", 1'b1, 3'd0, 4'd0, 1'b0, 32'd3, 32'hFFFF_FFFE, 32'd0, 2'b00);
    check("mul_val", 64'(ALUResultM), 64'hFFFF_FFFA);
    do_op("div", 1'b1, 3'd4, 4'd0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 2'b00);
    check("div_val", 64'(ALUResultM), 64'hFFFF_FFFD);
    do_op("rem", 1'b1, 3'd6, 4'd0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 2'b00);
    check("rem_val", 64'(ALUResultM), 64'hFFFF_FFFF);
    do_op("divu0", 1'b1, 3'd5, 4'd0, 1'b0, 32'd12345, 32'd0, 32'd0, 2'b00);
    check("divu0_val", 64'(ALUResultM), 64'hFFFF_FFFF);
    do_op("remu0", 1'b1, 3'd7, 4'd0, 1'b0, 32'd12345, 32'd0, 32'd0, 2'b00);
    check("remu0_val", 64'(ALUResultM), 64'd12345);
    do_op("divovf", 1'b1, 3'd4, 4'd0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2'b00);
    check("divovf_val", 64'(ALUResultM), 64'h8000_0000);
    do_op("removf", 1'b1, 3'd6, 4'd0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2'b00);
    check("removf_val", 64'(ALUResultM), 64'd0);

    do_op("pre_rst", 1'b0, 3'd0, 4'd3, 1'b1, 32'h1234_0000, 32'd0, 32'h0000_5678, 2'b00);
    rst_n = 1'b0;
    #1;
    check_m_zero("async_rst");
    rst_n = 1'b1;
    exp_alu_m = 32'd0;

    drive_op(1'b1, 3'd4, 4'd0, 1'b0, 32'd1000, 32'd3, 32'd0, 2'b00, 2'b00, 32'd0);
    #1;
    repeat (11) @(posedge clk);
    #1;
    check("mid_div_stall", 64'(StallE), 64'd1);
    rst_n = 1'b0;
    #1;
    check_m_zero("mid_div_rst");
    rst_n = 1'b1;
    exp_alu_m = 32'd0;
    do_op("divu_after_rst", 1'b1, 3'd5, 4'd0, 1'b0, 32'd100, 32'd7, 32'd0, 2'b00);
    check("divu_after_rst_val", 64'(ALUResultM), 64'd14);

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 9));
      r1 = rnd_val();
      r2 = rnd_val();
      if (kind < 2)
        drive_op(1'b1, 3'($urandom_range(4, 7)), 4'($urandom), 1'($urandom), r1, r2, rnd_val(),
                 2'($urandom), 2'($urandom), $urandom);
      else if (kind < 4)
        drive_op(1'b1, 3'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), r1, r2, rnd_val(),
                 2'($urandom), 2'($urandom), $urandom);
      else
        drive_op(1'b0, 3'($urandom), 4'($urandom), 1'($urandom), r1, r2, rnd_val(),
                 2'($urandom), 2'($urandom), $urandom);
      finish_op("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RV32IM pipeline. It sits between the ID/EX register and the Memory stage, and produces the full M-side bundle that the Memory stage consumes: `RegWriteM`, `ResultSrcM`, `MemWriteM`, `ALUResultM`, `WriteDataM`, `RdM` and `PCPlus4M`. It contains the operand-forwarding muxes, a single-cycle ALU and multiplier, and an iterative radix-2 divider that stalls the front of the pipeline. The EX/MEM pipeline register is part of this block.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `RegWriteE` in 1, `ResultSrcE` in 2, `MemWriteE` in 1: control fields from ID/EX.
- `ALUControlE` in 4: ALU operation select.
- `ALUSrcE` in 1: 1 selects `ImmExtE` as operand B.
- `MulDivE` in 1: 1 marks an M-extension operation.
- `Funct3E` in 3: M-extension operation code.
- `RD1E`, `RD2E`, `ImmExtE`, `PCPlus4E` in 32: ID/EX data fields.
- `RdE` in 5: destination register.
- `ForwardAE`, `ForwardBE` in 2: 00 selects the register value, 01 selects `ResultW`, 10 selects `ALUResultM`.
- `ResultW` in 32: writeback result used for forwarding.
- `StallE` out 1: 1 means hold IF, ID and ID/EX.
- `RegWriteM`, `ResultSrcM`, `MemWriteM`, `ALUResultM`, `WriteDataM`, `RdM`, `PCPlus4M` out: EX/MEM register outputs, same widths as their E-side sources.

## Operation
- **Operand selection.** SrcA = fwd(RD1E, ForwardAE). WriteDataE = fwd(RD2E, ForwardBE). SrcB = ALUSrcE ? ImmExtE : WriteDataE. The code 11 behaves as 00.
- **ALU codes (ALUControlE).**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU: result is 0 or 1, zero-extended.
  - 7 SLL, 8 SRL, 9 SRA: shift amount is SrcB[4:0].
  - Other codes produce 0.
- **Multiply (MulDivE=1, Funct3E 0–3), single cycle, full 64-bit product.**
  - 0 MUL: low 32 bits.
  - 1 MULH: high 32 bits, signed×signed.
  - 2 MULHSU: high 32 bits, signed×unsigned.
  - 3 MULHU: high 32 bits, unsigned×unsigned.
- **Divide (MulDivE=1, Funct3E 4–7): 4 DIV, 5 DIVU, 6 REM, 7 REMU.**
  - Implemented as an iterative restoring divider on magnitudes, with sign fix-up for the signed forms.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0.
  - Both special cases still take the full latency.
- **Divider FSM states: IDLE, BUSY, DONE.**
  - IDLE → BUSY when a divide is in E. On that transition, capture SrcA, SrcB, Funct3E and the sign flags, and clear the step counter.
  - BUSY: one quotient bit per cycle. Go to DONE when the counter reaches 31, after the 32nd step.
  - DONE: present the final result. Return to IDLE on the next edge.
- **StallE** = divide in E && state != DONE. It is combinational.
- **EX/MEM register update.**
  - If StallE = 1: load a bubble (RegWriteM=0, MemWriteM=0, all other fields 0).
  - Otherwise: load the E fields, with ALUResultM = div result if a divide is in E, else mul result if MulDivE=1, else the ALU result.

## Timing
- **Reset.** On `rst_n` low, immediately: every M output = 0, FSM = IDLE, counter = 0, StallE = 0. Reset during BUSY aborts the divide; the instruction is not retired.
- **Latency.** ALU, MUL, loads and stores: 1 cycle, E → M.
- **Divide latency.** A divide entering E at cycle t:
  - StallE is high during t..t+32.
  - DONE occurs at t+33, with StallE low.
  - The result is registered into M at the end of t+33: 34 cycles in E, 33 bubbles into M.
- **Operand capture.** Operands are captured at t, so forwarding changes during the stall have no effect.
- **Back-to-back divides.** DONE → IDLE, then the next divide starts 1 cycle later. No result is reused.

## Structure
- Package `execute_pkg` holds:
  - ALU code localparams (`ALU_ADD` … `ALU_SRA`).
  - M-extension funct3 localparams.
  - The divider state enum `div_state_t`.
  - Forward-select constants.
- Sub-module `Divider` contains the FSM, counter and the quotient/remainder registers.
  - Inputs: start, signed, rem, a, b.
  - Outputs: busy, done, result.
- ALU, multiplier and EX/MEM register stay inline.

## Test plan
- **ALU and forwarding.** ADD with RD1E=5, ImmExtE=−3, ALUSrcE=1 → ALUResultM=2 after 1 cycle. ForwardAE=10 with ALUResultM=7 feeds SrcA=7.
- **Shift and compare.** SRA of 0x80000000 by 4 → 0xF8000000. SLTU of 1 vs 0xFFFFFFFF → 1. SLT of the same → 0.
- **Multiply.** MULH of 0xFFFFFFFF × 0xFFFFFFFF → 0. MULHU of the same → 0xFFFFFFFE. MUL of 3 × −2 → 0xFFFFFFFA.
- **Divide timing.** DIV of −7 / 2:
  - StallE high for exactly 33 cycles.
  - RegWriteM=0 for those cycles.
  - Then ALUResultM=0xFFFFFFFD, RdM=RdE.
  - REM of the same operands → 0xFFFFFFFF.
- **Divide corner cases.**
  - DIVU by 0 → 0xFFFFFFFF.
  - REMU by 0 → dividend.
  - DIV of 0x80000000 / −1 → 0x80000000, and REM → 0.
  - Each of these still takes 33 stall cycles.
- **Reset mid-divide.** Assert rst_n low at BUSY step 10 → all M outputs and StallE go to 0 immediately. After release, a fresh DIVU of 100 / 7 → 14 with full latency.
